// File: rtl/reg_writeback_unit_pkg.sv
// Shared widths and the queued write-entry type for the register write-back path.
package reg_writeback_unit_pkg;

  localparam int DATA_W        = 32;
  localparam int ADDR_W        = 4;
  localparam int NUM_REGS      = 16;
  localparam int DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/reg_writeback_unit_fifo.sv
// Circular write queue: up to two ordered pushes and one pop per cycle,
// exposing every slot and its valid bit so the top can build the pending mask.
module wb_fifo
  import reg_writeback_unit_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_first,
  input  wb_entry_t             entry_first,
  input  logic                  push_second,
  input  wb_entry_t             entry_second,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [CNT_W-1:0]      count,
  output logic [DEPTH-1:0]      valid,
  output wb_entry_t [DEPTH-1:0] entries
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] second_slot;
  logic [DEPTH-1:0] valid_next;

  // The second push lands behind the first one when both arrive together.
  assign second_slot = wr_ptr + PTR_W'(push_first);
  assign head        = entries[rd_ptr];

  always_comb begin
    valid_next = valid;
    if (pop)         valid_next[rd_ptr]      = 1'b0;
    if (push_first)  valid_next[wr_ptr]      = 1'b1;
    if (push_second) valid_next[second_slot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      wr_ptr <= wr_ptr + PTR_W'(push_first) + PTR_W'(push_second);
      count  <= count + CNT_W'(push_first) + CNT_W'(push_second) - CNT_W'(pop);
      valid  <= valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_first)  entries[wr_ptr]      <= entry_first;
    if (push_second) entries[second_slot] <= entry_second;
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register write-back unit: merges load and ALU results into an ordered queue,
// drains one registered bank write per cycle and reports pending destinations.
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_mem_valid,
  input  logic [ADDR_W-1:0]   i_mem_dest,
  input  logic [DATA_W-1:0]   i_mem_data,
  output logic                o_mem_ready,
  input  logic                i_alu_valid,
  input  logic [ADDR_W-1:0]   i_alu_dest,
  input  logic [DATA_W-1:0]   i_alu_data,
  output logic                o_alu_ready,
  input  logic                i_stall,
  output logic                o_we,
  output logic [ADDR_W-1:0]   o_dest,
  output logic [DATA_W-1:0]   o_load,
  input  logic [ADDR_W-1:0]   i_chk_R1,
  input  logic [ADDR_W-1:0]   i_chk_R2,
  output logic                o_pend_R1,
  output logic                o_pend_R2,
  output logic [NUM_REGS-1:0] o_pend_mask,
  output logic [CNT_W-1:0]    o_count
);

  logic                  pop;
  logic                  mem_push;
  logic                  alu_push;
  logic [CNT_W-1:0]      free;
  logic [CNT_W-1:0]      count;
  logic [DEPTH-1:0]      valid;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [NUM_REGS-1:0]   pend_mask;

  // A slot freed by this cycle's pop may be refilled in the same cycle.
  assign pop         = (count != '0) && !i_stall;
  assign free        = CNT_W'(DEPTH) - count + CNT_W'(pop);
  assign o_mem_ready = free >= CNT_W'(1);
  assign o_alu_ready = free >= (CNT_W'(1) + CNT_W'(i_mem_valid));
  assign mem_push    = i_mem_valid && o_mem_ready;
  assign alu_push    = i_alu_valid && o_alu_ready;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (i_reset),
    .push_first   (mem_push),
    .entry_first  ('{dest: i_mem_dest, data: i_mem_data}),
    .push_second  (alu_push),
    .entry_second ('{dest: i_alu_dest, data: i_alu_data}),
    .pop          (pop),
    .head         (head),
    .count        (count),
    .valid        (valid),
    .entries      (entries)
  );

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) pend_mask = pend_mask | reg_onehot(entries[i].dest);
    end
  end

  assign o_pend_mask = pend_mask;
  assign o_pend_R1   = pend_mask[i_chk_R1];
  assign o_pend_R2   = pend_mask[i_chk_R2];
  assign o_count     = count;

  // Bank port is a registered copy of the popped head; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_we   <= 1'b0;
      o_dest <= '0;
      o_load <= '0;
    end else begin
      o_we <= pop;
      if (pop) begin
        o_dest <= head.dest;
        o_load <= head.data;
      end
    end
  end

endmodule
